// File: rtl/spi_boot_loader.sv
// Boot-time copier: reads the image from a SPI EEPROM with a single READ at
// address 0 and writes it word by word into the parallel SRAM. When the copy
// is complete it raises a sticky booted flag. Every output is registered.
module spi_boot_loader #(
   parameter int CLK_DIV    = 4,
   parameter int WORD_COUNT = 32768
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_spiMISO,
   output logic        o_spiMOSI,
   output logic        o_spiCLK,
   output logic        o_spiCSn,
   output logic [15:0] o_memAddr,
   output logic [15:0] o_memData,
   output logic        o_memWr,
   output logic        o_memEn,
   output logic        o_isBusy,
   output logic        o_isBooted
);

   typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, FINISH, DONE} state_t;

   localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [15:0]     LAST_WORD = 16'(WORD_COUNT - 1);
   localparam logic [23:0]     READ_CMD  = 24'h030000;  // opcode 0x03, address 0x0000

   state_t        state, nxt_state;
   logic [DW-1:0] div_cnt, nxt_div;
   logic          phase_hi, nxt_phase_hi;
   logic [4:0]    bit_cnt, nxt_bit, bit_inc;
   logic [15:0]   rx_words, nxt_rx;
   logic [15:0]   shift, nxt_shift;
   logic          wr_pend, nxt_wr_pend;
   logic          csn, nxt_csn, sclk, nxt_sclk, mosi, nxt_mosi;
   logic [15:0]   mem_addr, nxt_mem_addr, mem_data, nxt_mem_data;
   logic          mem_wr, nxt_mem_wr, mem_en, nxt_mem_en;
   logic          busy, nxt_busy, booted, nxt_booted;
   logic          tick;

   assign tick    = (div_cnt == DIV_LAST);
   assign bit_inc = bit_cnt + 5'd1;

   // Next-state and next-output logic; every output is the register of a value computed here.
   always_comb begin
      nxt_state    = state;
      nxt_div      = div_cnt;
      nxt_phase_hi = phase_hi;
      nxt_bit      = bit_cnt;
      nxt_rx       = rx_words;
      nxt_shift    = shift;
      nxt_wr_pend  = 1'b0;
      nxt_csn      = csn;
      nxt_sclk     = sclk;
      nxt_mosi     = mosi;
      nxt_mem_addr = mem_addr;
      nxt_mem_data = mem_data;
      nxt_mem_wr   = 1'b0;
      nxt_mem_en   = 1'b0;
      nxt_busy     = busy;
      nxt_booted   = booted;

      // A completed word is written one cycle after its last sample; rx_words
      // has not yet advanced at that point for any CLK_DIV, so it is the index.
      if (wr_pend) begin
         nxt_mem_wr   = 1'b1;
         nxt_mem_en   = 1'b1;
         nxt_mem_addr = rx_words;
         nxt_mem_data = shift;
      end

      if (state inside {SETUP, CMD, DATA, FINISH})
         nxt_div = tick ? '0 : div_cnt + DW'(1);

      case (state)
         IDLE: begin
            nxt_state = SETUP;
            nxt_csn   = 1'b0;
            nxt_busy  = 1'b1;
            nxt_div   = '0;
         end
         SETUP: begin
            if (tick) begin
               nxt_state    = CMD;
               nxt_phase_hi = 1'b0;
               nxt_bit      = 5'd0;
               nxt_mosi     = READ_CMD[23];
            end
         end
         CMD, DATA: begin
            if (tick) begin
               if (!phase_hi) begin
                  // End of low phase: raise SCLK and sample MISO on the same edge.
                  nxt_sclk     = 1'b1;
                  nxt_phase_hi = 1'b1;
                  nxt_shift    = {shift[14:0], i_spiMISO};
                  nxt_wr_pend  = (state == DATA) && (bit_cnt == 5'd15);
               end else begin
                  // End of high phase: drop SCLK and present the next MOSI bit.
                  nxt_sclk     = 1'b0;
                  nxt_phase_hi = 1'b0;
                  if (state == CMD) begin
                     if (bit_cnt == 5'd23) begin
                        nxt_state = DATA;
                        nxt_bit   = 5'd0;
                        nxt_mosi  = 1'b0;
                     end else begin
                        nxt_bit  = bit_inc;
                        nxt_mosi = READ_CMD[5'd23 - bit_inc];
                     end
                  end else if (bit_cnt == 5'd15) begin
                     nxt_bit = 5'd0;
                     nxt_rx  = rx_words + 16'd1;
                     if (rx_words == LAST_WORD)
                        nxt_state = FINISH;
                  end else begin
                     nxt_bit = bit_inc;
                  end
               end
            end
         end
         FINISH: begin
            if (tick) begin
               nxt_state  = DONE;
               nxt_csn    = 1'b1;
               nxt_busy   = 1'b0;
               nxt_booted = 1'b1;
            end
         end
         default: ;  // DONE is terminal until reset
      endcase
   end

   // State and output registers; reset forces every output immediately.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state    <= IDLE;
         div_cnt  <= '0;
         phase_hi <= 1'b0;
         bit_cnt  <= 5'd0;
         rx_words <= 16'd0;
         shift    <= 16'd0;
         wr_pend  <= 1'b0;
         csn      <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         mem_addr <= 16'd0;
         mem_data <= 16'd0;
         mem_wr   <= 1'b0;
         mem_en   <= 1'b0;
         busy     <= 1'b0;
         booted   <= 1'b0;
      end else begin
         state    <= nxt_state;
         div_cnt  <= nxt_div;
         phase_hi <= nxt_phase_hi;
         bit_cnt  <= nxt_bit;
         rx_words <= nxt_rx;
         shift    <= nxt_shift;
         wr_pend  <= nxt_wr_pend;
         csn      <= nxt_csn;
         sclk     <= nxt_sclk;
         mosi     <= nxt_mosi;
         mem_addr <= nxt_mem_addr;
         mem_data <= nxt_mem_data;
         mem_wr   <= nxt_mem_wr;
         mem_en   <= nxt_mem_en;
         busy     <= nxt_busy;
         booted   <= nxt_booted;
      end
   end

   assign o_spiCSn   = csn;
   assign o_spiCLK   = sclk;
   assign o_spiMOSI  = mosi;
   assign o_memAddr  = mem_addr;
   assign o_memData  = mem_data;
   assign o_memWr    = mem_wr;
   assign o_memEn    = mem_en;
   assign o_isBusy   = busy;
   assign o_isBooted = booted;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: a basic copy with an EEPROM model,
// mode-0 timing monitors, reset mid-copy, post-boot idle, and a
// CLK_DIV=1 / WORD_COUNT=1 instance with MISO held high.
module tb_spi_boot_loader;

   localparam int CDA = 2;
   localparam int WCA = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: CLK_DIV=2, WORD_COUNT=4
   logic        rstn_a = 1'b0, miso_a = 1'b0;
   logic        mosi_a, sclk_a, csn_a, wr_a, en_a, busy_a, booted_a;
   logic [15:0] addr_a, data_a;
   // instance B: CLK_DIV=1, WORD_COUNT=1
   logic        rstn_b = 1'b0, miso_b = 1'b1;
   logic        mosi_b, sclk_b, csn_b, wr_b, en_b, busy_b, booted_b;
   logic [15:0] addr_b, data_b;

   spi_boot_loader #(.CLK_DIV(CDA), .WORD_COUNT(WCA)) dut_a (
      .i_clk(clk), .i_rstn(rstn_a), .i_spiMISO(miso_a), .o_spiMOSI(mosi_a),
      .o_spiCLK(sclk_a), .o_spiCSn(csn_a), .o_memAddr(addr_a), .o_memData(data_a),
      .o_memWr(wr_a), .o_memEn(en_a), .o_isBusy(busy_a), .o_isBooted(booted_a));

   spi_boot_loader #(.CLK_DIV(1), .WORD_COUNT(1)) dut_b (
      .i_clk(clk), .i_rstn(rstn_b), .i_spiMISO(miso_b), .o_spiMOSI(mosi_b),
      .o_spiCLK(sclk_b), .o_spiCSn(csn_b), .o_memAddr(addr_b), .o_memData(data_b),
      .o_memWr(wr_b), .o_memEn(en_b), .o_isBusy(busy_b), .o_isBooted(booted_b));

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- instance A: EEPROM model and monitors ----------------
   logic [63:0] image_a = 64'h1234ABCD00FF8001;
   logic [23:0] cmd_cap_a = '0;
   logic [31:0] log_a [32];
   int rise_a = 0, hi_run_a = 0, lo_run_a = 0, csn_low_a = 0, csn_len_a = 0, wr_cnt_a = 0;
   int hp_bad_a = 0, mode_bad_a = 0, wr_bad_a = 0, idle_bad_a = 0, sync_bad_a = 0;
   logic psclk_a = 1'b0, pcsn_a = 1'b1, pmosi_a = 1'b0, pwr_a = 1'b0;

   always @(negedge clk) begin
      if (csn_a) begin
         if (!pcsn_a && rstn_a) csn_len_a = csn_low_a;
         rise_a = 0; hi_run_a = 0; lo_run_a = 0; csn_low_a = 0;
      end else begin
         csn_low_a++;
         if (sclk_a) begin
            if (!psclk_a) begin
               if (lo_run_a != ((rise_a == 0) ? 2*CDA : CDA)) hp_bad_a++;
               if (rise_a < 24) cmd_cap_a[23-rise_a] = mosi_a;
               rise_a++;
            end
            hi_run_a++; lo_run_a = 0;
         end else begin
            if (psclk_a && hi_run_a != CDA) hp_bad_a++;
            hi_run_a = 0; lo_run_a++;
         end
         if (mosi_a !== pmosi_a && !(psclk_a && !sclk_a) && !pcsn_a) mode_bad_a++;
      end
      // EEPROM presents the next data bit while SCLK is low
      if (rise_a >= 24 && rise_a < 24 + 16*WCA) miso_a = image_a[63-(rise_a-24)];
      else miso_a = 1'b0;
      if (wr_a) begin
         if (wr_cnt_a < 32) log_a[wr_cnt_a] = {addr_a, data_a};
         wr_cnt_a++;
         if (pwr_a) wr_bad_a++;
      end
      if (en_a !== wr_a) wr_bad_a++;
      if (booted_a && (csn_a !== 1'b1 || sclk_a || wr_a || en_a || busy_a)) idle_bad_a++;
      if (!csn_a && booted_a) sync_bad_a++;
      if (rstn_a && csn_a && !pcsn_a && !booted_a) sync_bad_a++;
      psclk_a = sclk_a; pcsn_a = csn_a; pmosi_a = mosi_a; pwr_a = wr_a;
   end

   // ---------------- instance B monitor ----------------
   int csn_low_b = 0, csn_len_b = 0, wr_cnt_b = 0;
   logic [31:0] last_b = '0;
   logic pcsn_b = 1'b1;

   always @(negedge clk) begin
      if (csn_b) begin
         if (!pcsn_b && rstn_b) csn_len_b = csn_low_b;
         csn_low_b = 0;
      end else csn_low_b++;
      if (wr_b) begin wr_cnt_b++; last_b = {addr_b, data_b}; end
      pcsn_b = csn_b;
   end

   function automatic logic [38:0] outs_a();
      return {csn_a, sclk_a, mosi_a, addr_a, data_a, wr_a, en_a, busy_a, booted_a};
   endfunction

   localparam logic [38:0] RST_OUTS = {1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};

   int base;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_outs_a", outs_a(), RST_OUTS);
      check("rst_outs_b", {csn_b, sclk_b, mosi_b, addr_b, data_b, wr_b, en_b, busy_b, booted_b}, RST_OUTS);

      // basic copy
      rstn_a = 1'b1;
      @(negedge clk);
      check("start_csn_busy", {csn_a, busy_a}, 2'b01);
      for (int i = 0; i < 2000 && !booted_a; i++) @(negedge clk);
      @(negedge clk);
      check("boot_a", booted_a, 1'b1);
      check("cmd_mosi", cmd_cap_a, 24'h030000);
      check("wr_count", wr_cnt_a, 4);
      check("wr0", log_a[0], 32'h0000_1234);
      check("wr1", log_a[1], 32'h0001_ABCD);
      check("wr2", log_a[2], 32'h0002_00FF);
      check("wr3", log_a[3], 32'h0003_8001);
      check("csn_low_len", csn_len_a, 356);
      check("done_csn_busy", {csn_a, busy_a}, 2'b10);
      check("half_period", hp_bad_a, 0);
      check("mosi_mode0", mode_bad_a, 0);
      check("wr_pulse", wr_bad_a, 0);
      check("csn_boot_sync", sync_bad_a, 0);

      // post-boot idle
      repeat (1000) @(negedge clk);
      check("idle_activity", idle_bad_a, 0);
      check("idle_state", {csn_a, sclk_a, wr_a, busy_a, booted_a}, 5'b10001);

      // restart, then reset in the middle of DATA after word 1 is written
      rstn_a = 1'b0;
      @(negedge clk);
      rstn_a = 1'b1;
      base = wr_cnt_a;
      for (int i = 0; i < 2000 && wr_cnt_a < base + 2; i++) @(negedge clk);
      check("mid_two_writes", wr_cnt_a - base, 2);
      @(posedge clk);
      #2 rstn_a = 1'b0;
      #1 check("async_rst_outs", outs_a(), RST_OUTS);
      repeat (3) @(negedge clk);
      check("held_rst_outs", outs_a(), RST_OUTS);
      rstn_a = 1'b1;
      base = wr_cnt_a;
      for (int i = 0; i < 2000 && !booted_a; i++) @(negedge clk);
      @(negedge clk);
      check("reboot_a", booted_a, 1'b1);
      check("reboot_wr_count", wr_cnt_a - base, 4);
      check("reboot_wr0", log_a[base], 32'h0000_1234);
      check("reboot_wr3", log_a[base+3], 32'h0003_8001);
      check("reboot_csn_len", csn_len_a, 356);
      check("reboot_wr_pulse", wr_bad_a, 0);

      // CLK_DIV=1, WORD_COUNT=1, MISO held high
      rstn_b = 1'b1;
      for (int i = 0; i < 500 && !booted_b; i++) @(negedge clk);
      @(negedge clk);
      check("boot_b", booted_b, 1'b1);
      check("b_wr_count", wr_cnt_b, 1);
      check("b_wr0", last_b, 32'h0000_FFFF);
      check("b_csn_len", csn_len_b, 82);
      check("b_done", {csn_b, busy_b, wr_b}, 3'b100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
